// File: rtl/usb_tx_encoder_if.sv
// Byte-source handshake and bus-pin bundle for the USB transmit encoder.
interface usb_tx_encoder_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       d_plus_out;
  logic       d_minus_out;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid, tx_last,
    input  tx_ready, d_plus_out, d_minus_out, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid, tx_last,
    output tx_ready, d_plus_out, d_minus_out, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// Bit-timed USB transmitter: SYNC prefix, LSB-first serialisation, bit stuffing,
// NRZI onto D+/D-, and SE0-SE0-J end of packet.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'h80
) (
  input  logic            clk,
  input  logic            n_rst,
  usb_tx_encoder_if.slave bus
);

  localparam int unsigned       CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned       IDX_W     = 3;
  localparam int unsigned       ONES_W    = 3;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(7);
  localparam logic [ONES_W-1:0] STUFF_RUN = ONES_W'(6);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [7:0]          byte_q, byte_d;
  logic                last_q, last_d;
  logic                stuff_sync_q, stuff_sync_d;
  logic                dp_q, dp_d;
  logic                dm_q, dm_d;
  logic                busy_q, busy_d;

  logic                wrap;
  logic                res_sync;
  logic [IDX_W-1:0]    idx_nxt;
  logic                emit;
  logic                emit_bit;
  logic                ready_c;
  logic                err_c;
  logic                done_c;

  // State register; reset returns the line to J immediately, abandoning any packet.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      ones_q       <= '0;
      byte_q       <= '0;
      last_q       <= 1'b0;
      stuff_sync_q <= 1'b0;
      dp_q         <= 1'b1;
      dm_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ones_q       <= ones_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      stuff_sync_q <= stuff_sync_d;
      dp_q         <= dp_d;
      dm_q         <= dm_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic: every decision is taken on the bit-timer wrap, and the line
  // register is loaded with the symbol for the bit period that starts next.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    ones_d       = ones_q;
    byte_d       = byte_q;
    last_d       = last_q;
    stuff_sync_d = stuff_sync_q;
    dp_d         = dp_q;
    dm_d         = dm_q;
    emit         = 1'b0;
    emit_bit     = 1'b1;
    ready_c      = 1'b0;
    err_c        = 1'b0;
    done_c       = 1'b0;

    wrap     = (cnt_q == CNT_LAST);
    idx_nxt  = idx_q + IDX_W'(1);
    // A stuff bit resumes the sequence it interrupted.
    res_sync = (state_q == S_SYNC) || ((state_q == S_STUFF) && stuff_sync_q);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        dp_d  = 1'b1;
        dm_d  = 1'b0;
        if (bus.tx_valid) begin
          ready_c  = 1'b1;
          byte_d   = bus.tx_data;
          last_d   = bus.tx_last;
          state_d  = S_SYNC;
          idx_d    = '0;
          emit     = 1'b1;
          emit_bit = SYNC_BYTE[0];
        end
      end

      S_SYNC, S_DATA, S_STUFF: begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        if (wrap) begin
          if ((state_q != S_STUFF) && (ones_q == STUFF_RUN)) begin
            state_d      = S_STUFF;
            stuff_sync_d = (state_q == S_SYNC);
            emit         = 1'b1;
            emit_bit     = 1'b0;
          end else if (res_sync && (idx_q != IDX_LAST)) begin
            state_d  = S_SYNC;
            idx_d    = idx_nxt;
            emit     = 1'b1;
            emit_bit = SYNC_BYTE[idx_nxt];
          end else if (res_sync) begin
            state_d  = S_DATA;
            idx_d    = '0;
            emit     = 1'b1;
            emit_bit = byte_q[0];
          end else if (idx_q != IDX_LAST) begin
            state_d  = S_DATA;
            idx_d    = idx_nxt;
            emit     = 1'b1;
            emit_bit = byte_q[idx_nxt];
          end else if (!last_q && bus.tx_valid) begin
            ready_c  = 1'b1;
            byte_d   = bus.tx_data;
            last_d   = bus.tx_last;
            state_d  = S_DATA;
            idx_d    = '0;
            emit     = 1'b1;
            emit_bit = bus.tx_data[0];
          end else begin
            // Final byte done, or the source ran dry mid-packet (truncate).
            err_c   = !last_q;
            state_d = S_EOP_SE0;
            idx_d   = '0;
            ones_d  = '0;
            dp_d    = 1'b0;
            dm_d    = 1'b0;
          end
        end
      end

      S_EOP_SE0: begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        if (wrap) begin
          if (idx_q == '0) begin
            idx_d = IDX_W'(1);
          end else begin
            state_d = S_EOP_J;
            idx_d   = '0;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end
        end
      end

      S_EOP_J: begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        if (wrap) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        ones_d  = '0;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
      end
    endcase

    // NRZI: a 0 toggles J<->K, a 1 holds; the run of ones feeds the stuffing rule.
    if (emit) begin
      if (!emit_bit) begin
        dp_d = ~dp_q;
        dm_d = ~dm_q;
      end
      ones_d = emit_bit ? ones_q + ONES_W'(1) : '0;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  assign bus.tx_ready    = ready_c & ~n_rst;
  assign bus.tx_err      = err_c   & ~n_rst;
  assign bus.tx_done     = done_c  & ~n_rst;
  assign bus.d_plus_out  = dp_q;
  assign bus.d_minus_out = dm_q;
  assign bus.tx_busy     = busy_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: expected line symbols come from a
// bitstream model (SYNC + stuffed data + EOP) built per packet.
module tb_usb_tx_encoder;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;
  localparam logic [7:0] SYNC = 8'h80;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       sel4;
  logic       tv;
  logic       tl;
  logic [7:0] td;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usb_tx_encoder_if bus8();
  usb_tx_encoder_if bus4();

  assign bus8.tx_valid = tv & ~sel4;
  assign bus8.tx_data  = td;
  assign bus8.tx_last  = tl;
  assign bus4.tx_valid = tv & sel4;
  assign bus4.tx_data  = td;
  assign bus4.tx_last  = tl;

  usb_tx_encoder #(.CLKS_PER_BIT(8), .SYNC_BYTE(8'h80)) dut8 (
    .clk(clk), .n_rst(n_rst), .bus(bus8.slave)
  );
  usb_tx_encoder #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'h80)) dut4 (
    .clk(clk), .n_rst(n_rst), .bus(bus4.slave)
  );

  // {d_plus, d_minus, busy, ready, done, err}
  wire [5:0] obs8 = {bus8.d_plus_out, bus8.d_minus_out, bus8.tx_busy,
                     bus8.tx_ready, bus8.tx_done, bus8.tx_err};
  wire [5:0] obs4 = {bus4.d_plus_out, bus4.d_minus_out, bus4.tx_busy,
                     bus4.tx_ready, bus4.tx_done, bus4.tx_err};
  wire [5:0] obs  = sel4 ? obs4 : obs8;

  logic [7:0] pkt_q[$];
  logic [1:0] m_sym[$];
  int         m_end[$];

  function automatic logic [1:0] flip(input logic [1:0] l);
    return (l == LJ) ? LK : LJ;
  endfunction

  function automatic void model_bit(input logic b, inout logic [1:0] line, inout int ones);
    if (!b) line = flip(line);
    m_sym.push_back(line);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      line = flip(line);
      m_sym.push_back(line);
      ones = 0;
    end
  endfunction

  // Build the symbol list for the first nsent bytes of pkt_q.
  function automatic void build_model(input int nsent);
    logic [1:0] line;
    logic [7:0] sb;
    logic [7:0] db;
    int         ones;
    m_sym.delete();
    m_end.delete();
    line = LJ;
    ones = 0;
    sb   = SYNC;
    for (int i = 0; i < 8; i++) model_bit(sb[i], line, ones);
    for (int k = 0; k < nsent; k++) begin
      db = pkt_q[k];
      for (int j = 0; j < 8; j++) model_bit(db[j], line, ones);
      m_end.push_back(m_sym.size() - 1);
    end
    m_sym.push_back(LSE0);
    m_sym.push_back(LSE0);
    m_sym.push_back(LJ);
  endfunction

  // Send pkt_q, offering only its first nsent bytes; compare every cycle.
  task automatic run_packet(input string name, input int nsent, input int max_cyc,
                            output int busy_cnt, output int rdy_cnt,
                            output int done_cnt, output int err_cnt);
    int         cpb, nsym, ncyc, ptr, err_at, last_c;
    int         rdy_at[$];
    logic [1:0] eline;
    logic       ebusy, erdy, edone, eerr;
    logic [5:0] expv;
    cpb = sel4 ? 4 : 8;
    build_model(nsent);
    nsym   = m_sym.size();
    last_c = nsym * cpb;
    for (int k = 0; k < nsent - 1; k++) rdy_at.push_back(m_end[k] * cpb + cpb);
    err_at = (nsent < pkt_q.size()) ? m_end[nsent-1] * cpb + cpb : -1;
    ncyc   = last_c + 4;
    if (max_cyc > 0 && max_cyc < ncyc) ncyc = max_cyc;
    busy_cnt = 0; rdy_cnt = 0; done_cnt = 0; err_cnt = 0;
    ptr = 0;
    @(posedge clk); #1;
    tv = 1'b1;
    td = pkt_q[0];
    tl = (pkt_q.size() == 1);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      eline = (c >= 1 && c <= last_c) ? m_sym[(c-1)/cpb] : LJ;
      ebusy = (c >= 1 && c <= last_c);
      edone = (c == last_c);
      eerr  = (c == err_at);
      erdy  = (c == 0);
      foreach (rdy_at[i]) if (rdy_at[i] == c) erdy = 1'b1;
      expv = {eline, ebusy, erdy, edone, eerr};
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL %s cycle %0d: dp,dm,busy,rdy,done,err got %b want %b", name, c, obs, expv);
      end
      if (obs[3]) busy_cnt++;
      if (obs[2]) begin rdy_cnt++; ptr++; end
      if (obs[1]) done_cnt++;
      if (obs[0]) err_cnt++;
      @(posedge clk); #1;
      tv = (ptr < nsent);
      td = (ptr < pkt_q.size()) ? pkt_q[ptr] : 8'($urandom);
      tl = (ptr == pkt_q.size() - 1);
    end
    tv = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b1; tv = 1'b0; tl = 1'b0; td = 8'h00; sel4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 tv = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs8 !== {LJ, 4'b0000}) begin
      n_err++; $display("FAIL reset8: got %b want %b", obs8, {LJ, 4'b0000});
    end
    n_vec++;
    if (obs4 !== {LJ, 4'b0000}) begin
      n_err++; $display("FAIL reset4: got %b want %b", obs4, {LJ, 4'b0000});
    end
    @(posedge clk); #1;
    n_rst = 1'b0; tv = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_byte();
    int b, r, d, e;
    pkt_q = '{8'h00};
    run_packet("zero_byte", 1, 0, b, r, d, e);
    check_int("zero_byte busy_cycles", b, 152);
    check_int("zero_byte ready_pulses", r, 1);
    check_int("zero_byte done_pulses", d, 1);
    check_int("zero_byte err_pulses", e, 0);
  endtask

  task automatic test_stuff_ff();
    int b, r, d, e;
    pkt_q = '{8'hFF};
    run_packet("stuff_ff", 1, 0, b, r, d, e);
    check_int("stuff_ff busy_cycles", b, 160);
    check_int("stuff_ff done_pulses", d, 1);
  endtask

  task automatic test_back_to_back();
    int b, r, d, e;
    pkt_q = '{8'hC3, 8'h5A};
    run_packet("back_to_back", 2, 0, b, r, d, e);
    check_int("b2b busy_cycles", b, 216);
    check_int("b2b ready_pulses", r, 2);
    check_int("b2b err_pulses", e, 0);
    check_int("b2b done_pulses", d, 1);
  endtask

  task automatic test_underrun();
    int b, r, d, e;
    pkt_q = '{8'hA5, 8'h3C};
    run_packet("underrun", 1, 0, b, r, d, e);
    check_int("underrun err_pulses", e, 1);
    check_int("underrun done_pulses", d, 1);
    check_int("underrun busy_cycles", b, 152);
  endtask

  task automatic test_reset_mid();
    int b, r, d, e;
    pkt_q = '{8'hFF};
    run_packet("reset_mid_pre", 1, 92, b, r, d, e);
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_vec++;
      if (obs8 !== {LJ, 4'b0000}) begin
        n_err++;
        $display("FAIL reset_mid idle cycle %0d: got %b want %b", c, obs8, {LJ, 4'b0000});
      end
    end
    pkt_q = '{8'hFF};
    run_packet("reset_mid_post", 1, 0, b, r, d, e);
    check_int("reset_mid post busy_cycles", b, 160);
  endtask

  task automatic test_cpb4();
    int b, r, d, e;
    sel4  = 1'b1;
    pkt_q = '{8'h00};
    run_packet("cpb4", 1, 0, b, r, d, e);
    check_int("cpb4 busy_cycles", b, 76);
    check_int("cpb4 done_pulses", d, 1);
    sel4 = 1'b0;
  endtask

  task automatic test_random();
    int b, r, d, e, n;
    for (int p = 0; p < 10; p++) begin
      n = $urandom_range(1, 4);
      pkt_q.delete();
      for (int k = 0; k < n; k++)
        pkt_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_packet("random", n, 0, b, r, d, e);
      check_int("random ready_pulses", r, n);
      check_int("random done_pulses", d, 1);
      check_int("random err_pulses", e, 0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_byte();
    test_stuff_ff();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_cpb4();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
Serial USB packet transmitter. It is the encoding counterpart of the receive-path decode, timer and rcu chain.
- Accepts packet bytes over a valid/ready byte handshake.
- Prepends SYNC, serialises LSB-first, inserts stuff bits and NRZI-encodes onto D+/D-.
- Terminates every packet with EOP (SE0, SE0, J).
- Sits between the transmit control unit (byte source) and the bus pins; it replaces the separate shift and output stages with one bit-timed engine.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit time (must be >= 2)
SYNC_BYTE, 8'h80, SYNC pattern, sent LSB-first

Ports:
clk  input  1  system clock
n_rst  input  1  synchronous, active-high reset; name kept per codebase port naming, reset asserted when 1
tx_data  input  8  next packet byte (PID first)
tx_valid  input  1  tx_data/tx_last valid
tx_last  input  1  qualifies tx_data as final byte of packet
tx_ready  output  1  1-cycle pulse: byte on tx_data/tx_last accepted this cycle
d_plus_out  output  1  D+ line
d_minus_out  output  1  D- line
tx_busy  output  1  high from byte acceptance in IDLE until EOP_J completes
tx_done  output  1  1-cycle pulse on final cycle of EOP_J
tx_err  output  1  1-cycle pulse on underrun

Behaviour:
- Reset (sampled on posedge clk while n_rst=1): state=IDLE, line=J (d_plus_out=1, d_minus_out=0), bit counter=0, ones counter=0, tx_ready/tx_busy/tx_done/tx_err=0. Reset mid-packet aborts immediately: J on the next edge, no EOP, no tx_done.
- Bit timer: counts 0..CLKS_PER_BIT-1 while not IDLE; the line changes only on the cycle the counter wraps. Each bit period is exactly CLKS_PER_BIT cycles.
- NRZI: bit 0 toggles the line (J<->K, where K is d_plus_out=0, d_minus_out=1). Bit 1 holds the line.
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE:
  - If tx_valid=1: tx_ready=1 that cycle and the byte and its last flag are latched.
  - Goes to SYNC. The first SYNC bit drives the line on the next cycle (latency 1).
  - tx_valid=0: stays IDLE in J.
- SYNC: 8 bits of SYNC_BYTE, LSB first. The default produces K J K J K J K K. The ones counter tracks from the SYNC bits onward.
- DATA: latched byte, LSB first.
  - Each 1 increments the ones counter; each 0 clears it.
  - When the count reaches 6, the next bit period is STUFF: forced 0 (toggle), counter cleared, data bit deferred.
- STUFF: one bit time, then return to DATA. If the stuff followed bit 7, proceed as for end-of-byte.
- End of byte (last bit or trailing stuff completes):
  - Latched last=0 and tx_valid=1: tx_ready pulses, the next byte is latched, DATA continues with no gap.
  - Latched last=0 and tx_valid=0: underrun. tx_err pulses and the block goes to EOP_SE0 (packet truncated).
  - Latched last=1: go to EOP_SE0; tx_valid is ignored.
- EOP_SE0: both lines 0 for 2 bit times.
- EOP_J: J for 1 bit time. tx_done pulses on its last cycle, then IDLE. A tx_valid in the next cycle starts a new packet.
- The stuff bit is always sent before EOP, even after the final byte.
- tx_ready never asserts outside IDLE or end-of-byte. tx_busy deasserts the cycle after tx_done.
- Packet time = 8 SYNC + 8*N data + stuff bits + 3 EOP bit times.

Test Plan:
- Reset, then 1-byte packet 0x00 with tx_last=1 → line K J K J K J K K, then J K J K J K J K, SE0, SE0, J. 19 bit times = 152 clk; tx_done pulses once; tx_ready pulses once.
- Byte 0xFF, last → SYNC, 5 held bits, stuff toggle after data bit 4, 3 held bits, EOP. Total 20 bit times.
- Back-to-back packet of 0xC3, 0x5A, last with tx_valid held → tx_ready pulses exactly at each byte boundary; no idle bit between bytes; no tx_err.
- Two-byte packet, tx_valid dropped at the end of byte 1 → tx_err pulse; EOP follows immediately; tx_done pulses; returns to IDLE in J.
- n_rst=1 during DATA bit 3 → next cycle line=J and tx_busy=0; no tx_done. Next packet starts cleanly with ones counter reset.
- CLKS_PER_BIT=4 instance, byte 0x00 → every line transition is a multiple of 4 cycles after start; total 76 clk.
